// File: rtl/float_to_double.sv
// ============================================================================
// Module   : float_to_double
// Purpose  : Multi-cycle IEEE-754 single-to-double converter over stb/ack
//            channels. Optional macro F2D_CANON_NAN_EN: canonical NaN output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_to_double (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A     = 3'd0,
        UNPACK    = 3'd1,
        NORMALISE = 3'd2,
        PACK      = 3'd3,
        PUT_Z     = 3'd4
    } state_t;

    localparam logic [10:0] C_EXP_BIAS_DIFF = 11'd896;
    localparam logic [10:0] C_EXP_SUBNORM   = 11'd897;

    state_t      state_q;
    logic        ack_q;
    logic        stb_q;
    logic [63:0] z_q;
    logic [63:0] z_d;

    logic        s_q;
    logic [7:0]  e_q;
    logic [22:0] m_q;
    logic [23:0] mant_q;
    logic [10:0] exp_q;
    logic        is_zero_q;
    logic        is_inf_q;
    logic        is_nan_q;

    // Packed result for whichever class UNPACK recorded.
    always_comb begin
        z_d = {s_q, exp_q, mant_q[22:0], 29'b0};
        if (is_nan_q) begin
`ifdef F2D_CANON_NAN_EN
            z_d = 64'h7FF8_0000_0000_0000;
`else
            z_d = {s_q, 11'h7FF, 1'b1, m_q[21:0], 29'b0};
`endif
        end else if (is_inf_q) begin
            z_d = {s_q, 11'h7FF, 52'b0};
        end else if (is_zero_q) begin
            z_d = {s_q, 63'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GET_A;
            ack_q     <= 1'b0;
            stb_q     <= 1'b0;
            z_q       <= 64'b0;
            s_q       <= 1'b0;
            e_q       <= 8'b0;
            m_q       <= 23'b0;
            mant_q    <= 24'b0;
            exp_q     <= 11'b0;
            is_zero_q <= 1'b0;
            is_inf_q  <= 1'b0;
            is_nan_q  <= 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    ack_q <= 1'b1;
                    if (ack_q && input_a_stb) begin
                        s_q     <= input_a[31];
                        e_q     <= input_a[30:23];
                        m_q     <= input_a[22:0];
                        ack_q   <= 1'b0;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    is_zero_q <= 1'b0;
                    is_inf_q  <= 1'b0;
                    is_nan_q  <= 1'b0;
                    if (e_q == 8'hFF) begin
                        is_nan_q <= (m_q != 23'b0);
                        is_inf_q <= (m_q == 23'b0);
                        state_q  <= PACK;
                    end else if (e_q == 8'h00) begin
                        if (m_q == 23'b0) begin
                            is_zero_q <= 1'b1;
                            state_q   <= PACK;
                        end else begin
                            mant_q  <= {1'b0, m_q};
                            exp_q   <= C_EXP_SUBNORM;
                            state_q <= NORMALISE;
                        end
                    end else begin
                        exp_q   <= {3'b0, e_q} + C_EXP_BIAS_DIFF;
                        mant_q  <= {1'b1, m_q};
                        state_q <= PACK;
                    end
                end
                NORMALISE: begin
                    // Leave on the shift that lands the leading one in bit 23,
                    // so a subnormal costs exactly one cycle per shift.
                    if (mant_q[23]) begin
                        state_q <= PACK;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - 11'd1;
                        if (mant_q[22]) begin
                            state_q <= PACK;
                        end
                    end
                end
                PACK: begin
                    z_q     <= z_d;
                    stb_q   <= 1'b1;
                    state_q <= PUT_Z;
                end
                PUT_Z: begin
                    if (stb_q && output_z_ack) begin
                        stb_q   <= 1'b0;
                        state_q <= GET_A;
                    end
                end
                default: begin
                    state_q <= GET_A;
                end
            endcase
        end
    end

    assign input_a_ack  = ack_q;
    assign output_z     = z_q;
    assign output_z_stb = stb_q;

endmodule

`default_nettype wire

// File: tb/tb_float_to_double.sv
// ============================================================================
// Module   : tb_float_to_double
// Purpose  : Self-checking bench for float_to_double (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_float_to_double;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int n_vec;
    int n_err;

    float_to_double u_dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level conversion of a binary32 to binary64.
    function automatic logic [63:0] ref_f2d(input logic [31:0] a);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        int          p;
        longint unsigned fr;
        logic [10:0] de;
        s = a[31];
        e = a[30:23];
        m = a[22:0];
        if (e == 8'hFF) begin
            if (m == 23'd0) return {s, 11'h7FF, 52'd0};
`ifdef F2D_CANON_NAN_EN
            return 64'h7FF8_0000_0000_0000;
`else
            return {s, 11'h7FF, 1'b1, m[21:0], 29'd0};
`endif
        end
        if (e == 8'd0 && m == 23'd0) return {s, 63'd0};
        if (e == 8'd0) begin
            // value = m * 2^-149 = 1.f * 2^(p-149), p = leading-one position
            p = 0;
            for (int i = 0; i < 23; i++) if (m[i]) p = i;
            de = 11'(p - 149 + 1023);
            fr = longint'(m) & ~(64'd1 << p);
            fr = fr << (52 - p);
            return {s, de, fr[51:0]};
        end
        de = 11'(int'(e) - 127 + 1023);
        return {s, de, m, 29'd0};
    endfunction

    function automatic int ref_lat(input logic [31:0] a);
        int p;
        if (a[30:23] != 8'd0 || a[22:0] == 23'd0) return 2;
        p = 0;
        for (int i = 0; i < 23; i++) if (a[i]) p = i;
        return 2 + (23 - p);
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check32(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic wait_ack_high(output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        while (input_a_ack !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 1000) begin
                ok = 1'b0;
                check32("ack_timeout", 1, 0);
                return;
            end
        end
    endtask

    // One transaction: present a, measure latency, apply bp_cycles of backpressure.
    task automatic do_op(input logic [31:0] a, input int bp_cycles, input string tag);
        logic [63:0] expz;
        int          lat;
        bit          ok;
        int          bad;
        expz = ref_f2d(a);
        wait_ack_high(ok);
        if (!ok) return;
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_a     = $urandom;
        lat = 0;
        while (output_z_stb !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 1000) begin
                check32({tag, "_stb_timeout"}, 1, 0);
                return;
            end
        end
        check32({tag, "_latency"}, lat, ref_lat(a));
        check64({tag, "_z"}, output_z, expz);
        bad = 0;
        for (int i = 0; i < bp_cycles; i++) begin
            @(posedge clk); #1;
            if (output_z !== expz || output_z_stb !== 1'b1 || input_a_ack !== 1'b0) bad++;
        end
        if (bp_cycles > 0) check32({tag, "_hold"}, bad, 0);
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        check32({tag, "_stb_ack_after_accept"}, {30'd0, output_z_stb, input_a_ack}, 0);
        @(posedge clk); #1;
        check32({tag, "_ack_rise"}, {31'd0, input_a_ack}, 1);
    endtask

    initial begin
        logic [31:0] r;
        int          cls;
        int          bad;
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        input_a      = 32'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check32("reset_ack", {31'd0, input_a_ack}, 0);
        check32("reset_stb", {31'd0, output_z_stb}, 0);
        check64("reset_z", output_z, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check32("ack_after_reset", {31'd0, input_a_ack}, 1);

        // Directed vectors, with literal expectations
        check64("lit_one",    ref_f2d(32'h3F800000), 64'h3FF0000000000000);
        do_op(32'h3F800000, 0, "one");
        check64("lit_pi",     ref_f2d(32'hC0490FDB), 64'hC00921FB60000000);
        do_op(32'hC0490FDB, 1, "negpi");
        check64("lit_submin", ref_f2d(32'h00000001), 64'h36A0000000000000);
        do_op(32'h00000001, 0, "submin");
        check64("lit_subtop", ref_f2d(32'h00400000), 64'h3800000000000000);
        do_op(32'h00400000, 0, "subtop");
        check64("lit_submax", ref_f2d(32'h807FFFFF), 64'hB80FFFFFC0000000);
        do_op(32'h807FFFFF, 0, "submax");
        do_op(32'h80000000, 0, "negzero");
        do_op(32'h7F800000, 0, "posinf");
        do_op(32'hFF800000, 0, "neginf");
`ifdef F2D_CANON_NAN_EN
        check64("lit_nan", ref_f2d(32'hFFC00001), 64'h7FF8000000000000);
`else
        check64("lit_nan", ref_f2d(32'hFFC00001), 64'hFFF8000020000000);
        check64("lit_snan", ref_f2d(32'h7F800001), 64'h7FF8000020000000);
`endif
        do_op(32'hFFC00001, 0, "qnan");
        do_op(32'h7F800001, 0, "snan");

        // Backpressure, then back-to-back operands
        do_op(32'h3F800000, 10, "bp_one");
        do_op(32'h40000000, 0, "bp_two");

        // Reset mid-NORMALISE
        input_a     = 32'h00000001;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        bad = 0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (output_z_stb !== 1'b0) bad++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check32("abort_zero_out", {30'd0, output_z_stb, input_a_ack}, 0);
        check64("abort_zero_z", output_z, 64'd0);
        @(posedge clk); #1;
        check32("abort_ack_rise", {31'd0, input_a_ack}, 1);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (output_z_stb !== 1'b0) bad++;
        end
        check32("abort_no_stb", bad, 0);
        do_op(32'h3F800000, 0, "post_abort");

        // Randomized operands weighted toward each class
        for (int n = 0; n < 200; n++) begin
            r   = $urandom;
            cls = int'($urandom_range(0, 4));
            case (cls)
                1: r[30:23] = 8'h00;
                2: r[30:23] = 8'hFF;
                3: r[30:0]  = 31'd0;
                4: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h80;
                default: ;
            endcase
            if (cls == 1 && $urandom_range(0, 1) == 1) r[22:0] = 23'd1 << $urandom_range(0, 22);
            do_op(r, int'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
